// File: rtl/lcd_fifo_pkg.sv
// Shared definitions for the LCD pixel FIFO controllers (read and write side).
package lcd_fifo_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_CNT_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FILL     = 2'd1,
    ST_STREAM   = 2'd2,
    ST_UNDERRUN = 2'd3
  } ctl_state_t;
endpackage

// File: rtl/lcd_fifo_rd_ctl_if.sv
// Bus between the pixel FIFO read port, the LCD timing generator and the read controller.
interface lcd_fifo_rd_ctl_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 10,
  parameter int UCNT_W = 16
) ();
  logic              enable;
  logic              lcd_frame_start;
  logic              lcd_data_requst;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_rd_cnt;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] lcd_data;
  logic              lcd_data_valid;
  logic [UCNT_W-1:0] underrun_cnt;
  logic [1:0]        ctl_state;

  // master: the controller itself
  modport master (
    input  enable, lcd_frame_start, lcd_data_requst, fifo_empty, fifo_rd_cnt, fifo_rd_data,
    output fifo_rd_en, lcd_data, lcd_data_valid, underrun_cnt, ctl_state
  );

  modport slave (
    output enable, lcd_frame_start, lcd_data_requst, fifo_empty, fifo_rd_cnt, fifo_rd_data,
    input  fifo_rd_en, lcd_data, lcd_data_valid, underrun_cnt, ctl_state
  );
endinterface

// File: rtl/lcd_fifo_rd_ctl_sat_counter.sv
// Increment-only counter that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_cnt <= '0;
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/lcd_fifo_rd_ctl.sv
// FIFO-to-LCD read controller: fill/resume hysteresis, underrun substitution, frame resync.
module lcd_fifo_rd_ctl
  import lcd_fifo_pkg::*;
#(
  parameter int                DATA_W       = DEF_DATA_W,
  parameter int                CNT_W        = DEF_CNT_W,
  parameter int                START_LEVEL  = 128,
  parameter int                RESUME_LEVEL = 64,
  parameter logic [DATA_W-1:0] FILL_PIXEL   = '0,
  parameter int                UCNT_W       = 16
) (
  input logic              fifo_rd_clk,
  input logic              rst,
  lcd_fifo_rd_ctl_if.master bus
);
  localparam logic [CNT_W-1:0] START_L  = CNT_W'(START_LEVEL);
  localparam logic [CNT_W-1:0] RESUME_L = CNT_W'(RESUME_LEVEL);

  ctl_state_t        r_state, w_state_nxt;
  logic              r_start_ok, r_resume_ok;
  logic              r_req_d, r_en_d;
  logic [DATA_W-1:0] r_lcd_data;
  logic              r_lcd_valid;
  logic              w_rd_en, w_underrun;

  // Level compares are registered to keep the wide compare off the state path.
  always_ff @(posedge fifo_rd_clk or posedge rst) begin
    if (rst) begin
      r_start_ok  <= 1'b0;
      r_resume_ok <= 1'b0;
    end else begin
      r_start_ok  <= (bus.fifo_rd_cnt > START_L)  && !bus.fifo_empty;
      r_resume_ok <= (bus.fifo_rd_cnt > RESUME_L) && !bus.fifo_empty;
    end
  end

  always_ff @(posedge fifo_rd_clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_underrun  = 1'b0;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_FILL;
      ST_FILL:  if (r_start_ok) w_state_nxt = ST_STREAM;
      ST_STREAM: begin
        w_rd_en    = bus.lcd_data_requst && !bus.fifo_empty;
        w_underrun = bus.lcd_data_requst && bus.fifo_empty;
        if (bus.lcd_frame_start)                          w_state_nxt = ST_FILL;
        else if (bus.lcd_data_requst && bus.fifo_empty)   w_state_nxt = ST_UNDERRUN;
      end
      ST_UNDERRUN: begin
        w_underrun = bus.lcd_data_requst;
        if (bus.lcd_frame_start) w_state_nxt = ST_FILL;
        else if (r_resume_ok)    w_state_nxt = ST_STREAM;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!bus.enable) w_state_nxt = ST_IDLE;
    if (rst)         w_rd_en     = 1'b0;
  end

  // FIFO data lands one cycle after the read, so the request/read flags are
  // staged once and the pixel is captured when the FIFO output is valid.
  always_ff @(posedge fifo_rd_clk or posedge rst) begin
    if (rst) begin
      r_req_d     <= 1'b0;
      r_en_d      <= 1'b0;
      r_lcd_data  <= '0;
      r_lcd_valid <= 1'b0;
    end else begin
      r_req_d     <= bus.lcd_data_requst;
      r_en_d      <= w_rd_en;
      r_lcd_valid <= r_req_d;
      if (r_req_d) r_lcd_data <= r_en_d ? bus.fifo_rd_data : FILL_PIXEL;
    end
  end

  sat_counter #(.W(UCNT_W)) u_ucnt (
    .clk   (fifo_rd_clk),
    .rst   (rst),
    .i_inc (w_underrun),
    .o_cnt (bus.underrun_cnt)
  );

  assign bus.fifo_rd_en     = w_rd_en;
  assign bus.lcd_data       = r_lcd_data;
  assign bus.lcd_data_valid = r_lcd_valid;
  assign bus.ctl_state      = r_state;
endmodule

// File: tb/tb_lcd_fifo_rd_ctl.sv
// Directed bench for lcd_fifo_rd_ctl with a small standard-FIFO read model.
module tb_lcd_fifo_rd_ctl;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 10;
  localparam int UCNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [DATA_W-1:0] pop_val = 16'd1;

  lcd_fifo_rd_ctl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .UCNT_W(UCNT_W)) bus ();

  lcd_fifo_rd_ctl #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .START_LEVEL(128), .RESUME_LEVEL(64),
    .FILL_PIXEL(16'h0000), .UCNT_W(UCNT_W)
  ) dut (
    .fifo_rd_clk (clk),
    .rst         (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Standard (non-FWFT) FIFO: a pop at an edge presents the next word after it.
  initial bus.fifo_rd_data = '0;
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_rd_data <= pop_val;
      pop_val          <= pop_val + 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 0; bus.lcd_frame_start = 0; bus.lcd_data_requst = 0;
    bus.fifo_empty = 0; bus.fifo_rd_cnt = '0;
    #1;
    check("rst_state", 32'(bus.ctl_state), 0);
    check("rst_rd_en", 32'(bus.fifo_rd_en), 0);
    check("rst_valid", 32'(bus.lcd_data_valid), 0);
    check("rst_data",  32'(bus.lcd_data), 0);
    check("rst_ucnt",  32'(bus.underrun_cnt), 0);
    bus.enable = 1; bus.lcd_data_requst = 1;
    tick(); tick();
    check("rst_hold_state", 32'(bus.ctl_state), 0);
    check("rst_hold_rd_en", 32'(bus.fifo_rd_en), 0);
    bus.lcd_data_requst = 0;
    tick(); tick();
    rst = 1'b0;

    // Fill with strict threshold
    tick();
    check("fill_enter", 32'(bus.ctl_state), 1);
    bus.fifo_rd_cnt = 10'd128;
    tick(); tick();
    check("fill_eq128", 32'(bus.ctl_state), 1);
    bus.fifo_rd_cnt = 10'd129;
    tick();
    check("fill_129_reg", 32'(bus.ctl_state), 1);
    tick();
    check("fill_to_stream", 32'(bus.ctl_state), 2);
    check("stream_valid0", 32'(bus.lcd_data_valid), 0);

    // Streaming: 8 requests
    for (int i = 0; i < 8; i++) begin
      bus.lcd_data_requst = 1;
      #1;
      check("strm_rd_en", 32'(bus.fifo_rd_en), 1);
      tick();
      if (i == 0) check("strm_valid_lat", 32'(bus.lcd_data_valid), 0);
      else begin
        check("strm_valid", 32'(bus.lcd_data_valid), 1);
        check("strm_data", 32'(bus.lcd_data), 32'(i));
      end
    end
    bus.lcd_data_requst = 0;
    #1;
    check("strm_idle_rd_en", 32'(bus.fifo_rd_en), 0);
    tick();
    check("strm_last_valid", 32'(bus.lcd_data_valid), 1);
    check("strm_last_data", 32'(bus.lcd_data), 8);
    tick();
    check("strm_done_valid", 32'(bus.lcd_data_valid), 0);
    check("strm_hold_data", 32'(bus.lcd_data), 8);
    check("strm_ucnt", 32'(bus.underrun_cnt), 0);

    // Underrun: 3 requests against an empty FIFO
    bus.fifo_empty = 1; bus.fifo_rd_cnt = '0; bus.lcd_data_requst = 1;
    #1;
    check("ur_rd_en", 32'(bus.fifo_rd_en), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k > 0) begin
        check("ur_valid", 32'(bus.lcd_data_valid), 1);
        check("ur_fill", 32'(bus.lcd_data), 0);
      end
    end
    bus.lcd_data_requst = 0;
    tick();
    check("ur_fill_last", 32'(bus.lcd_data), 0);
    check("ur_ucnt", 32'(bus.underrun_cnt), 3);
    check("ur_state", 32'(bus.ctl_state), 3);
    bus.fifo_empty = 0; bus.fifo_rd_cnt = 10'd64;
    tick(); tick();
    check("ur_eq64", 32'(bus.ctl_state), 3);
    bus.fifo_rd_cnt = 10'd65;
    tick();
    check("ur_65_reg", 32'(bus.ctl_state), 3);
    tick();
    check("ur_resume", 32'(bus.ctl_state), 2);

    // Frame resync coinciding with a request
    bus.fifo_rd_cnt = 10'd200;
    tick();
    check("fs_pre_state", 32'(bus.ctl_state), 2);
    bus.lcd_data_requst = 1; bus.lcd_frame_start = 1;
    #1;
    check("fs_rd_en", 32'(bus.fifo_rd_en), 1);
    tick();
    check("fs_to_fill", 32'(bus.ctl_state), 1);
    bus.lcd_data_requst = 0; bus.lcd_frame_start = 0;
    tick();
    check("fs_back_stream", 32'(bus.ctl_state), 2);
    check("fs_data", 32'(bus.lcd_data), 9);
    check("fs_valid", 32'(bus.lcd_data_valid), 1);
    check("fs_ucnt", 32'(bus.underrun_cnt), 3);

    // Saturation of the 4-bit underrun counter
    bus.fifo_empty = 1; bus.fifo_rd_cnt = '0; bus.lcd_data_requst = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 10) check("sat_14", 32'(bus.underrun_cnt), 14);
    end
    check("sat_15", 32'(bus.underrun_cnt), 15);
    bus.lcd_data_requst = 0; bus.enable = 0;
    tick();
    check("dis_state", 32'(bus.ctl_state), 0);
    check("dis_ucnt", 32'(bus.underrun_cnt), 15);

    // Async reset mid-burst
    bus.enable = 1; bus.fifo_empty = 0; bus.fifo_rd_cnt = 10'd200;
    tick(); tick(); tick();
    check("ar_stream", 32'(bus.ctl_state), 2);
    bus.lcd_data_requst = 1;
    tick(); tick();
    check("ar_valid_pre", 32'(bus.lcd_data_valid), 1);
    check("ar_rd_en_pre", 32'(bus.fifo_rd_en), 1);
    #2 rst = 1'b1;
    #1;
    check("ar_rd_en", 32'(bus.fifo_rd_en), 0);
    check("ar_valid", 32'(bus.lcd_data_valid), 0);
    check("ar_state", 32'(bus.ctl_state), 0);
    check("ar_data", 32'(bus.lcd_data), 0);
    check("ar_ucnt", 32'(bus.underrun_cnt), 0);
    bus.lcd_data_requst = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
